// File: rtl/sipo_frame_deser.sv
// sipo_frame_deser: parametrised serial-in/parallel-out frame deserializer
module sipo_frame_deser #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 0,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             clear,
  output logic [WIDTH-1:0] shift_q,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);
  logic [WIDTH-1:0] shift_d;
  logic             last;
  // next shift value for the configured bit order, and final-bit detect
  always_comb begin
    shift_d = LSB_FIRST ? {s_in, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], s_in};
    last    = bit_cnt == CW'(WIDTH - 1);
  end
  // shift register, bit counter and completed-word capture; clear beats s_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      p_out   <= '0;
      p_valid <= 1'b0;
      bit_cnt <= '0;
    end else if (clear) begin
      shift_q <= '0;
      p_valid <= 1'b0;
      bit_cnt <= '0;
    end else begin
      p_valid <= s_valid && last;
      if (s_valid) begin
        shift_q <= shift_d;
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        if (last) p_out <= shift_d;
      end
    end
  end
  assign busy = bit_cnt != '0;
endmodule

// File: doc/sipo_frame_deser.md
Name: sipo_frame_deser

Overview:
Parametrised serial-in/parallel-out deserializer, the successor to our fixed 4-bit SIPO. It accepts one qualified serial bit per clock, assembles WIDTH-bit frames in MSB-first or LSB-first order, and presents each completed word on a held parallel output with a one-cycle valid strobe. It sits between a serial bit source and word-wide consumer logic.

Parameters:
WIDTH, 8, frame/word width in bits; legal range 2..32.
LSB_FIRST, 0, bit order: 0 = first received bit lands in p_out[WIDTH-1]; 1 = first received bit lands in p_out[0].
CW, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
s_valid  input  1  qualifies s_in; a bit is accepted only on cycles with s_valid=1.
s_in  input  1  serial data bit.
clear  input  1  synchronous abort of the partial frame.
shift_q  output  WIDTH  live shift-register contents (debug/observation).
p_out  output  WIDTH  last completed word; held until the next frame completes.
p_valid  output  1  one-cycle pulse in the cycle p_out updates.
busy  output  1  high while a partial frame is held (bit_cnt != 0).
bit_cnt  output  CW  number of bits accepted in the current frame (0..WIDTH-1).

Behaviour:
- Reset (async, rst=1): shift_q=0, p_out=0, p_valid=0, bit_cnt=0, busy=0. Takes effect immediately, not at the next edge. Reset mid-frame discards the partial frame. The first frame after reset release starts at bit 0.
- Accept: on a rising edge with s_valid=1 and clear=0:
  - LSB_FIRST=0: shift_q <= {shift_q[WIDTH-2:0], s_in}.
  - LSB_FIRST=1: shift_q <= {s_in, shift_q[WIDTH-1:1]}.
  - bit_cnt increments.
- s_valid=0: shift_q, bit_cnt and p_out hold. Gaps of any length inside a frame are legal.
- Frame completion: the edge that accepts a bit with bit_cnt==WIDTH-1 has these effects:
  - p_out <= the assembled word including that bit. This is the same value shift_q takes on that edge.
  - p_valid=1 for exactly that following cycle.
  - bit_cnt wraps to 0.
  - Latency: p_out/p_valid are registered and visible in the cycle after the final bit's accepting edge.
- Back-to-back frames: continuous s_valid gives p_valid once every WIDTH cycles. There are no dead cycles, and bit 0 of the next frame is accepted on the cycle after completion.
- p_valid is 0 on every cycle not immediately following a completing edge.
- clear=1 (sync) has these effects:
  - shift_q <= 0 and bit_cnt <= 0.
  - p_out holds and p_valid <= 0.
  - clear wins over a simultaneous s_valid: that bit is discarded, and a frame that would have completed on that edge does not complete.
- busy = (bit_cnt != 0), combinational from the register.
- No internal state machine beyond the counter: state IDLE is bit_cnt==0, state SHIFT is bit_cnt!=0. SHIFT returns to IDLE on completion or clear.

Test Plan:
- WIDTH=4, LSB_FIRST=0. Apply rst for 1 cycle, then send s_valid=1 bits 1,0,1,1 on consecutive edges -> p_out=4'b1011, p_valid high for exactly 1 cycle after the 4th edge, bit_cnt sequence 1,2,3,0.
- WIDTH=4, LSB_FIRST=1, same stream 1,0,1,1 -> p_out=4'b1101. Follow with 0,0,1,0 back-to-back -> second pulse exactly 4 cycles later with p_out=4'b0100.
- WIDTH=8, LSB_FIRST=0. Send 0xA5 MSB-first with s_valid low for 3 cycles between bits 3 and 4 -> no pulse during the gap, bit_cnt holds at 4, final p_out=8'hA5.
- WIDTH=4. Complete frame 1011, then send 2 bits of the next frame, then pulse clear -> bit_cnt=0, busy=0, shift_q=0, p_out still 4'b1011, no p_valid. Then send 0,1,1,0 -> p_out=4'b0110.
- WIDTH=4. After 3 bits, assert clear together with s_valid=1 on the would-be 4th bit -> no p_valid, bit_cnt=0, p_out unchanged.
- Assert rst asynchronously mid-cycle after 2 bits -> all outputs 0 immediately, before the next clk edge. After release, frame 1,1,0,0 -> p_out=4'b1100.
